// File: rtl/gen_lane_pipeline.sv
// gen_lane_pipeline: elastic STAGES-deep register pipeline with a MODE-selected entry transform.
// Define GEN_LANE_PIPELINE_PARITY_EN to carry a per-beat parity bit out on out_parity.
module gen_lane_pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]            beat_count
`ifdef GEN_LANE_PIPELINE_PARITY_EN
  ,
  output logic                        out_parity
`endif
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [WIDTH-1:0]  t_data;
  logic [STAGES-1:0] s_valid;
  logic [WIDTH-1:0]  s_data [STAGES];
  logic [STAGES:0]   rdy;

  generate
    if (MODE == 0) begin : g_pass
      assign t_data = in_data;
    end else if (MODE == 1) begin : g_inv
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign t_data[i] = ~in_data[i];
      end
    end else if (MODE == 2) begin : g_rol
      assign t_data = {in_data[WIDTH-2:0], in_data[WIDTH-1]};
    end else begin : g_zero
      assign t_data = '0;
    end
  endgenerate

  // A stage can take new data if it is empty or everything downstream of it will move.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !s_valid[k] || rdy[k+1];
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = s_valid[STAGES-1] && !flush;
  assign out_data  = s_data[STAGES-1];

`ifdef GEN_LANE_PIPELINE_PARITY_EN
  logic [STAGES-1:0] s_par;
  assign out_parity = s_par[STAGES-1];
`endif

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             nxt_valid;
      logic [WIDTH-1:0] nxt_data;
      logic             v_q;
      logic [WIDTH-1:0] d_q;

      if (k == 0) begin : g_head
        assign nxt_valid = in_valid && !flush;
        assign nxt_data  = t_data;
      end else begin : g_body
        assign nxt_valid = s_valid[k-1];
        assign nxt_data  = s_data[k-1];
      end

      // Flush drops valids only; data is left in place.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (flush) begin
          v_q <= 1'b0;
        end else if (rdy[k]) begin
          v_q <= nxt_valid;
          if (nxt_valid) d_q <= nxt_data;
        end
      end

      assign s_valid[k] = v_q;
      assign s_data[k]  = d_q;

`ifdef GEN_LANE_PIPELINE_PARITY_EN
      logic nxt_par;
      logic p_q;

      if (k == 0) begin : g_par_head
        assign nxt_par = ^t_data;
      end else begin : g_par_body
        assign nxt_par = s_par[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q <= 1'b0;
        end else if (!flush && rdy[k] && nxt_valid) begin
          p_q <= nxt_par;
        end
      end

      assign s_par[k] = p_q;
`endif
    end
  endgenerate

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(s_valid[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (out_valid && out_ready) begin
      beat_count <= beat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gen_lane_pipeline.sv
// Bench for gen_lane_pipeline: four instances (MODE 0..3) share one stimulus stream and
// are checked every cycle against a queue-of-beats model of the elastic pipeline.
module tb_gen_lane_pipeline;

  localparam int S = 3;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        ir  [4];
  logic        ov  [4];
  logic [7:0]  od  [4];
  logic [1:0]  occ [4];
  logic [15:0] bc0;
  logic [3:0]  bc1, bc2, bc3;
`ifdef GEN_LANE_PIPELINE_PARITY_EN
  logic        par [4];
`endif

  int n_cmp = 0;
  int n_err = 0;

  gen_lane_pipeline #(.WIDTH(8), .STAGES(S), .MODE(0), .CNT_W(16)) u_m0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .occupancy(occ[0]), .beat_count(bc0)
`ifdef GEN_LANE_PIPELINE_PARITY_EN
    , .out_parity(par[0])
`endif
  );

  gen_lane_pipeline #(.WIDTH(8), .STAGES(S), .MODE(1), .CNT_W(4)) u_m1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .occupancy(occ[1]), .beat_count(bc1)
`ifdef GEN_LANE_PIPELINE_PARITY_EN
    , .out_parity(par[1])
`endif
  );

  gen_lane_pipeline #(.WIDTH(8), .STAGES(S), .MODE(2), .CNT_W(4)) u_m2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
    .occupancy(occ[2]), .beat_count(bc2)
`ifdef GEN_LANE_PIPELINE_PARITY_EN
    , .out_parity(par[2])
`endif
  );

  gen_lane_pipeline #(.WIDTH(8), .STAGES(S), .MODE(3), .CNT_W(4)) u_m3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od[3]), .out_ready(out_ready),
    .occupancy(occ[3]), .beat_count(bc3)
`ifdef GEN_LANE_PIPELINE_PARITY_EN
    , .out_parity(par[3])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xf(input int mode, input logic [7:0] x);
    case (mode)
      0:       return x;
      1:       return ~x;
      2:       return {x[6:0], x[7]};
      default: return 8'h00;
    endcase
  endfunction

  // Model: ordered list of beats in flight (oldest first), each with its stage position.
  typedef struct {
    logic [7:0] raw;
    int         pos;
  } beat_t;

  beat_t       q[$];
  logic [31:0] cnt = 0;
  bit          m_pop, m_acc;
  bit          m_mv [S];
  int          m_n;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cnt = 0;
      end else if (flush) begin
        q.delete();
      end else begin
        m_n   = q.size();
        m_acc = in_valid && (m_n < S || out_ready);
        m_pop = m_n > 0 && q[0].pos == S - 1 && out_ready;
        // A beat advances when some slot ahead of it is free or the output drains.
        for (int i = 0; i < m_n; i++)
          m_mv[i] = (q[i].pos < S - 1) && (((S - 1 - q[i].pos) > i) || out_ready);
        for (int i = 0; i < m_n; i++)
          if (m_mv[i]) q[i].pos = q[i].pos + 1;
        if (m_pop) begin
          void'(q.pop_front());
          cnt = cnt + 1;
        end
        if (m_acc) q.push_back('{raw: in_data, pos: 0});
      end
    end
  end

  bit e_ir, e_ov;

  initial begin
    forever begin
      @(negedge clk);
      e_ir = !flush && (q.size() < S || out_ready);
      e_ov = !flush && q.size() > 0 && q[0].pos == S - 1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("m%0d_in_ready", i), 32'(ir[i]), 32'(e_ir));
        chk($sformatf("m%0d_out_valid", i), 32'(ov[i]), 32'(e_ov));
        chk($sformatf("m%0d_occupancy", i), 32'(occ[i]), 32'(q.size()));
        if (e_ov) chk($sformatf("m%0d_out_data", i), 32'(od[i]), 32'(xf(i, q[0].raw)));
      end
      chk("m0_beat_count", 32'(bc0), 32'(cnt[15:0]));
      chk("m1_beat_count", 32'(bc1), 32'(cnt[3:0]));
      chk("m2_beat_count", 32'(bc2), 32'(cnt[3:0]));
      chk("m3_beat_count", 32'(bc3), 32'(cnt[3:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_out_data", 32'(od[0]), 0);
    chk("rst_occupancy", 32'(occ[0]), 0);
    chk("rst_in_ready", 32'(ir[0]), 1);
    chk("rst_beat_count", 32'(bc0), 0);

    // Latency and entry transforms
    step(); in_valid = 1'b1; in_data = 8'hA5;
    step(); in_data = 8'h0F;
    step(); in_data = 8'h81;
    @(negedge clk);
    chk("lat_not_early", 32'(ov[0]), 0);
    step(); in_data = 8'hFF;
    @(negedge clk);
    chk("lat_out_valid", 32'(ov[0]), 1);
    chk("lat_out_data", 32'(od[0]), 32'h A5);
    chk("lat_count_pre", 32'(bc0), 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lat_count_post", 32'(bc0), 1);
    chk("mode1_invert", 32'(od[1]), 32'h F0);
    step();
    @(negedge clk);
    chk("mode2_rotate", 32'(od[2]), 32'h 03);
    step();
    @(negedge clk);
    chk("mode3_zero_valid", 32'(ov[3]), 1);
    chk("mode3_zero", 32'(od[3]), 32'h 00);
    repeat (3) step();

    // Stall fill and drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk); chk("fill_occ0", 32'(occ[0]), 0);
    step(); in_data = 8'h02;
    @(negedge clk); chk("fill_occ1", 32'(occ[0]), 1);
    step(); in_data = 8'h03;
    @(negedge clk); chk("fill_occ2", 32'(occ[0]), 2);
    step(); in_data = 8'h04;
    @(negedge clk);
    chk("fill_occ3", 32'(occ[0]), 3);
    chk("fill_in_ready", 32'(ir[0]), 0);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", 32'(ir[0]), 1);
    chk("drain_d1", 32'(od[0]), 32'h01);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("drain_d2", 32'(od[0]), 32'h02);
    chk("drain_occ", 32'(occ[0]), 3);
    step(); @(negedge clk); chk("drain_d3", 32'(od[0]), 32'h03);
    step(); @(negedge clk); chk("drain_d4", 32'(od[0]), 32'h04);
    step();

    // Full pipe with simultaneous accept and output
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin in_data = 8'($urandom); step(); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      chk("full_occ", 32'(occ[0]), 3);
      chk("full_in_ready", 32'(ir[0]), 1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(bc0), 18);
    repeat (3) step();

    // Flush with two beats held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    step(); in_data = 8'h22;
    step(); flush = 1'b1; out_ready = 1'b1; in_data = 8'h33;
    @(negedge clk);
    chk("flush_out_valid", 32'(ov[0]), 0);
    chk("flush_in_ready", 32'(ir[0]), 0);
    chk("flush_occ_pre", 32'(occ[0]), 2);
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ_post", 32'(occ[0]), 0);
    chk("flush_count", 32'(bc0), 21);

    // Asynchronous reset between edges with three beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin in_data = 8'($urandom); step(); end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ov[0]), 0);
    chk("arst_occ", 32'(occ[0]), 0);
    chk("arst_count", 32'(bc0), 0);
    step(); rst = 1'b0;

    // 4-bit counter wrap: 17 beats leave 1
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (17) begin in_data = 8'($urandom); step(); end
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("wrap_cnt4", 32'(bc1), 1);
    chk("wrap_cnt16", 32'(bc0), 17);

    // Randomized traffic
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
